// File: rtl/phys_reg_file_pkg.sv
// Shared widths and issue/PRF operand-read payloads for the physical register file.
package phys_reg_file_pkg;

    localparam int unsigned PRF_SIZE = 64;
    localparam int unsigned TAG_W    = $clog2(PRF_SIZE);
    localparam int unsigned XLEN     = 32;

    typedef logic [TAG_W-1:0] prf_tag_t;
    typedef logic [XLEN-1:0]  prf_data_t;

    typedef struct packed {
        prf_tag_t read_tag_1;
        prf_tag_t read_tag_2;
    } is_prf_packet_t;

    typedef struct packed {
        prf_data_t read_out_1;
        prf_data_t read_out_2;
    } prf_is_packet_t;

    // CDB broadcast matches a lookup tag this cycle
    function automatic logic cdb_match(input logic valid, input prf_tag_t cdb_tag,
                                       input prf_tag_t tag);
        return valid && (cdb_tag == tag);
    endfunction

endpackage

// File: rtl/phys_reg_file_bypass_mux.sv
// Selects between a stored entry and the same-cycle CDB broadcast for one lookup port.
module prf_bypass_mux
    import phys_reg_file_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter bit          BLOCK_TAG0 = 1'b1
) (
    input  logic           cdb_valid,
    input  prf_tag_t       cdb_tag,
    input  logic [W-1:0]   cdb_data,
    input  prf_tag_t       sel_tag,
    input  logic [W-1:0]   stored,
    output logic [W-1:0]   value_c
);

    logic hit_c;

    // Tag 0 is hardwired, so its lookups never take the broadcast on value ports
    always_comb begin
        hit_c = cdb_match(cdb_valid, cdb_tag, sel_tag);
        if (BLOCK_TAG0 && (sel_tag == '0)) begin
            hit_c = 1'b0;
        end
        value_c = hit_c ? cdb_data : stored;
    end

endmodule

// File: rtl/phys_reg_file.sv
// Physical register file: two same-cycle operand reads, CDB writeback, per-tag ready bits.
module phys_reg_file
    import phys_reg_file_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  is_prf_packet_t      is_prf_packet,
    output prf_is_packet_t      prf_is_packet,
    input  logic                cdb_valid,
    input  prf_tag_t            cdb_tag,
    input  prf_data_t           cdb_value,
    input  logic                alloc_en,
    input  prf_tag_t            alloc_tag,
    input  prf_tag_t            rdy_tag_1,
    input  prf_tag_t            rdy_tag_2,
    output logic                rdy_1,
    output logic                rdy_2,
    input  logic                squash,
    input  logic [PRF_SIZE-1:0] arch_ready
);

    prf_data_t           regs [PRF_SIZE];
    logic [PRF_SIZE-1:0] ready;
    logic [PRF_SIZE-1:0] ready_nxt;
    logic                cdb_wr;
    prf_data_t           stored_1;
    prf_data_t           stored_2;

    assign cdb_wr   = cdb_valid && (cdb_tag != '0);
    assign stored_1 = regs[is_prf_packet.read_tag_1];
    assign stored_2 = regs[is_prf_packet.read_tag_2];

    // Value storage; entry 0 is never written and stays zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(PRF_SIZE); i++) begin
                regs[i] <= '0;
            end
        end else if (cdb_wr) begin
            regs[cdb_tag] <= cdb_value;
        end
    end

    // Ready priority: squash recovery, then alloc, then CDB completion
    always_comb begin
        ready_nxt = ready;
        if (cdb_wr) begin
            ready_nxt[cdb_tag] = 1'b1;
        end
        if (alloc_en && (alloc_tag != '0)) begin
            ready_nxt[alloc_tag] = 1'b0;
        end
        if (squash) begin
            ready_nxt = ready | arch_ready;
        end
        ready_nxt[0] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready <= '1;
        end else begin
            ready <= ready_nxt;
        end
    end

    prf_bypass_mux #(.W(XLEN), .BLOCK_TAG0(1'b1)) u_read_1 (
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_value),
        .sel_tag   (is_prf_packet.read_tag_1),
        .stored    (stored_1),
        .value_c   (prf_is_packet.read_out_1)
    );

    prf_bypass_mux #(.W(XLEN), .BLOCK_TAG0(1'b1)) u_read_2 (
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_value),
        .sel_tag   (is_prf_packet.read_tag_2),
        .stored    (stored_2),
        .value_c   (prf_is_packet.read_out_2)
    );

    // Ready lookups: a broadcast completing this cycle reads as ready
    prf_bypass_mux #(.W(1), .BLOCK_TAG0(1'b0)) u_rdy_1 (
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (1'b1),
        .sel_tag   (rdy_tag_1),
        .stored    (ready[rdy_tag_1]),
        .value_c   (rdy_1)
    );

    prf_bypass_mux #(.W(1), .BLOCK_TAG0(1'b0)) u_rdy_2 (
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (1'b1),
        .sel_tag   (rdy_tag_2),
        .stored    (ready[rdy_tag_2]),
        .value_c   (rdy_2)
    );

endmodule

// File: tb/tb_phys_reg_file.sv
// Self-checking bench for phys_reg_file against an array-based reference model.
module tb_phys_reg_file;
    import phys_reg_file_pkg::*;

    logic                clock = 1'b0;
    logic                reset_n;
    is_prf_packet_t      is_prf_packet;
    prf_is_packet_t      prf_is_packet;
    logic                cdb_valid;
    prf_tag_t            cdb_tag;
    prf_data_t           cdb_value;
    logic                alloc_en;
    prf_tag_t            alloc_tag;
    prf_tag_t            rdy_tag_1;
    prf_tag_t            rdy_tag_2;
    logic                rdy_1;
    logic                rdy_2;
    logic                squash;
    logic [PRF_SIZE-1:0] arch_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_val [64];
    logic [63:0] m_rdy;

    always #5 clock = ~clock;

    phys_reg_file dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .is_prf_packet (is_prf_packet),
        .prf_is_packet (prf_is_packet),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .alloc_en      (alloc_en),
        .alloc_tag     (alloc_tag),
        .rdy_tag_1     (rdy_tag_1),
        .rdy_tag_2     (rdy_tag_2),
        .rdy_1         (rdy_1),
        .rdy_2         (rdy_2),
        .squash        (squash),
        .arch_ready    (arch_ready)
    );

    function automatic logic [31:0] exp_read(input int t);
        if (t == 0) return 32'h0;
        if (cdb_valid && int'(cdb_tag) == t) return cdb_value;
        return m_val[t];
    endfunction

    function automatic logic exp_rdy(input int t);
        if (cdb_valid && int'(cdb_tag) == t) return 1'b1;
        return m_rdy[t];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_val[i] = 32'h0;
        m_rdy = '1;
    endtask

    task automatic idle();
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_value  = '0;
        alloc_en   = 1'b0;
        alloc_tag  = '0;
        squash     = 1'b0;
        arch_ready = '0;
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle
    task automatic tick();
        logic [31:0] nv [64];
        logic [63:0] nr;
        for (int i = 0; i < 64; i++) nv[i] = m_val[i];
        nr = m_rdy;
        if (cdb_valid && cdb_tag != 0) begin
            nv[int'(cdb_tag)] = cdb_value;
            nr[int'(cdb_tag)] = 1'b1;
        end
        if (alloc_en && alloc_tag != 0) nr[int'(alloc_tag)] = 1'b0;
        if (squash) nr = m_rdy | arch_ready;
        nr[0] = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 64; i++) m_val[i] = nv[i];
        m_rdy = nr;
        #1;
    endtask

    task automatic lookup(input int r1, input int r2, input int q1, input int q2);
        is_prf_packet.read_tag_1 = TAG_W'(r1);
        is_prf_packet.read_tag_2 = TAG_W'(r2);
        rdy_tag_1 = TAG_W'(q1);
        rdy_tag_2 = TAG_W'(q2);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        lookup(5, 63, 5, 63);
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'h0) begin n_err++; $display("FAIL reset_read1 got=%h exp=0", prf_is_packet.read_out_1); end
        n_cmp++; if (prf_is_packet.read_out_2 !== 32'h0) begin n_err++; $display("FAIL reset_read2 got=%h exp=0", prf_is_packet.read_out_2); end
        n_cmp++; if (rdy_1 !== 1'b1 || rdy_2 !== 1'b1) begin n_err++; $display("FAIL reset_rdy got=%b%b exp=11", rdy_1, rdy_2); end
        #2 reset_n = 1'b1;
        tick();
        lookup(5, 63, 5, 63);
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'h0 || prf_is_packet.read_out_2 !== 32'h0) begin n_err++; $display("FAIL post_reset_read got=%h/%h exp=0/0", prf_is_packet.read_out_1, prf_is_packet.read_out_2); end
        n_cmp++; if (rdy_1 !== 1'b1 || rdy_2 !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy got=%b%b exp=11", rdy_1, rdy_2); end
    endtask

    task automatic test_write_read();
        idle();
        cdb_valid = 1'b1; cdb_tag = TAG_W'(7); cdb_value = 32'hDEADBEEF;
        tick();
        idle();
        lookup(7, 7, 7, 3);
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_read got=%h exp=deadbeef", prf_is_packet.read_out_1); end
        n_cmp++; if (prf_is_packet.read_out_2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL same_tag_port2 got=%h exp=deadbeef", prf_is_packet.read_out_2); end
        n_cmp++; if (rdy_1 !== 1'b1) begin n_err++; $display("FAIL write_rdy got=%b exp=1", rdy_1); end
    endtask

    task automatic test_bypass();
        idle();
        alloc_en = 1'b1; alloc_tag = TAG_W'(9);
        tick();
        idle();
        lookup(0, 9, 9, 9);
        n_cmp++; if (rdy_1 !== 1'b0) begin n_err++; $display("FAIL alloc_rdy got=%b exp=0", rdy_1); end
        cdb_valid = 1'b1; cdb_tag = TAG_W'(9); cdb_value = 32'h1234;
        #1;
        n_cmp++; if (prf_is_packet.read_out_2 !== 32'h1234) begin n_err++; $display("FAIL bypass_read got=%h exp=1234", prf_is_packet.read_out_2); end
        n_cmp++; if (rdy_1 !== 1'b1) begin n_err++; $display("FAIL bypass_rdy got=%b exp=1", rdy_1); end
        tick();
        idle();
        #1;
        n_cmp++; if (prf_is_packet.read_out_2 !== 32'h1234 || rdy_2 !== 1'b1) begin n_err++; $display("FAIL bypass_commit got=%h/%b exp=1234/1", prf_is_packet.read_out_2, rdy_2); end
    endtask

    task automatic test_tag0();
        idle();
        lookup(0, 0, 0, 0);
        cdb_valid = 1'b1; cdb_tag = '0; cdb_value = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'h0) begin n_err++; $display("FAIL tag0_bypass got=%h exp=0", prf_is_packet.read_out_1); end
        tick();
        idle();
        #1;
        n_cmp++; if (prf_is_packet.read_out_2 !== 32'h0) begin n_err++; $display("FAIL tag0_write got=%h exp=0", prf_is_packet.read_out_2); end
        alloc_en = 1'b1; alloc_tag = '0;
        tick();
        idle();
        #1;
        n_cmp++; if (rdy_1 !== 1'b1) begin n_err++; $display("FAIL tag0_alloc got=%b exp=1", rdy_1); end
    endtask

    task automatic test_collision();
        idle();
        alloc_en = 1'b1; alloc_tag = TAG_W'(12);
        cdb_valid = 1'b1; cdb_tag = TAG_W'(12); cdb_value = 32'h55;
        tick();
        idle();
        lookup(12, 0, 12, 0);
        n_cmp++; if (rdy_1 !== 1'b0) begin n_err++; $display("FAIL collision_rdy got=%b exp=0", rdy_1); end
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'h55) begin n_err++; $display("FAIL collision_val got=%h exp=55", prf_is_packet.read_out_1); end
        cdb_valid = 1'b1; cdb_tag = TAG_W'(12); cdb_value = 32'h66;
        tick();
        idle();
        #1;
        n_cmp++; if (rdy_1 !== 1'b1 || prf_is_packet.read_out_1 !== 32'h66) begin n_err++; $display("FAIL collision_done got=%b/%h exp=1/66", rdy_1, prf_is_packet.read_out_1); end
    endtask

    task automatic test_squash();
        idle();
        cdb_valid = 1'b1; cdb_tag = TAG_W'(20); cdb_value = 32'hA0A0;
        tick();
        idle();
        cdb_valid = 1'b1; cdb_tag = TAG_W'(21); cdb_value = 32'hB1B1;
        tick();
        idle();
        alloc_en = 1'b1; alloc_tag = TAG_W'(20);
        tick();
        alloc_tag = TAG_W'(21);
        tick();
        idle();
        lookup(20, 21, 20, 21);
        n_cmp++; if (rdy_1 !== 1'b0 || rdy_2 !== 1'b0) begin n_err++; $display("FAIL squash_pre_rdy got=%b%b exp=00", rdy_1, rdy_2); end
        squash = 1'b1;
        arch_ready = '0;
        arch_ready[20] = 1'b1;
        alloc_en = 1'b1; alloc_tag = TAG_W'(20);
        tick();
        idle();
        #1;
        n_cmp++; if (rdy_1 !== 1'b1) begin n_err++; $display("FAIL squash_rdy20 got=%b exp=1", rdy_1); end
        n_cmp++; if (rdy_2 !== 1'b0) begin n_err++; $display("FAIL squash_rdy21 got=%b exp=0", rdy_2); end
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'hA0A0 || prf_is_packet.read_out_2 !== 32'hB1B1) begin n_err++; $display("FAIL squash_vals got=%h/%h exp=a0a0/b1b1", prf_is_packet.read_out_1, prf_is_packet.read_out_2); end
    endtask

    function automatic int rand_tag();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 63));
        return int'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        int r1, r2, q1, q2;
        for (int c = 0; c < 400; c++) begin
            idle();
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = TAG_W'(rand_tag());
            cdb_value = $urandom;
            alloc_en  = ($urandom_range(0, 2) == 0);
            alloc_tag = TAG_W'(rand_tag());
            if ($urandom_range(0, 19) == 0) begin
                squash = 1'b1;
                arch_ready = {$urandom, $urandom} & {$urandom, $urandom};
            end
            r1 = rand_tag(); r2 = rand_tag(); q1 = rand_tag(); q2 = rand_tag();
            lookup(r1, r2, q1, q2);
            n_cmp++; if (prf_is_packet.read_out_1 !== exp_read(r1)) begin n_err++; $display("FAIL rand_read1 c=%0d tag=%0d got=%h exp=%h", c, r1, prf_is_packet.read_out_1, exp_read(r1)); end
            n_cmp++; if (prf_is_packet.read_out_2 !== exp_read(r2)) begin n_err++; $display("FAIL rand_read2 c=%0d tag=%0d got=%h exp=%h", c, r2, prf_is_packet.read_out_2, exp_read(r2)); end
            n_cmp++; if (rdy_1 !== exp_rdy(q1)) begin n_err++; $display("FAIL rand_rdy1 c=%0d tag=%0d got=%b exp=%b", c, q1, rdy_1, exp_rdy(q1)); end
            n_cmp++; if (rdy_2 !== exp_rdy(q2)) begin n_err++; $display("FAIL rand_rdy2 c=%0d tag=%0d got=%b exp=%b", c, q2, rdy_2, exp_rdy(q2)); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        cdb_valid = 1'b1; cdb_tag = TAG_W'(30); cdb_value = 32'hCAFE;
        tick();
        idle();
        alloc_en = 1'b1; alloc_tag = TAG_W'(31);
        tick();
        idle();
        lookup(30, 30, 31, 31);
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'hCAFE || rdy_1 !== 1'b0) begin n_err++; $display("FAIL async_pre got=%h/%b exp=cafe/0", prf_is_packet.read_out_1, rdy_1); end
        cdb_valid = 1'b1; cdb_tag = TAG_W'(40); cdb_value = 32'h1;
        #1 reset_n = 1'b0;
        #1;
        idle();
        model_reset();
        #1;
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'h0) begin n_err++; $display("FAIL async_clear_val got=%h exp=0", prf_is_packet.read_out_1); end
        n_cmp++; if (rdy_1 !== 1'b1) begin n_err++; $display("FAIL async_clear_rdy got=%b exp=1", rdy_1); end
        @(posedge clock);
        #2 reset_n = 1'b1;
        tick();
        lookup(40, 30, 40, 31);
        n_cmp++; if (prf_is_packet.read_out_1 !== 32'h0 || rdy_2 !== 1'b1) begin n_err++; $display("FAIL async_lost_write got=%h/%b exp=0/1", prf_is_packet.read_out_1, rdy_2); end
    endtask

    initial begin
        is_prf_packet = '0;
        rdy_tag_1 = '0;
        rdy_tag_2 = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_tag0();
        test_collision();
        test_squash();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
